// File: rtl/spi_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared types and constants for the SPI register-access initiator.
//   state_t    : controller FSM states
//   FRAME_W    : width of one register-access frame
//   CPOL_BIT   : index of CPOL inside the 2-bit mode input
//   CPHA_BIT   : index of CPHA inside the 2-bit mode input
//   pack_frame : builds {wr_rdn, addr[6:0], data[7:0]}, sent MSB first
// ---------------------------------------------------------------------------
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        LAG,
        GAP
    } state_t;

    localparam int FRAME_W  = 16;
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic       wr_rdn,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        return {wr_rdn, addr, data};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
// Half-period divider and SCLK driver for the SPI initiator.
//   clk    : system clock
//   rstb   : synchronous active-low reset
//   hold   : keeps the divider at zero (controller idle)
//   toggle : SCLK toggles on each tick while high, parks at cpol while low
//   cpol   : idle level of SCLK
//   tick   : one-cycle pulse every CLK_DIV clk cycles while not held
//   sclk   : registered SCLK output
// ---------------------------------------------------------------------------
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic hold,
    input  logic toggle,
    input  logic cpol,
    output logic tick,
    output logic sclk
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] div_cnt_reg;
    logic             sclk_reg;

    assign tick = !hold && (div_cnt_reg == CNT_W'(CLK_DIV - 1));
    assign sclk = sclk_reg;

    // Every controller state change other than leaving IDLE happens on a
    // tick, where the counter wraps to zero, so each state starts a fresh
    // half-period.
    always_ff @(posedge clk) begin
        if (!rstb || hold) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sclk_reg <= 1'b0;
        end else if (toggle) begin
            if (tick) begin
                sclk_reg <= ~sclk_reg;
            end
        end else begin
            sclk_reg <= cpol;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
// SPI initiator that turns one parallel register request into a 16-bit
// frame {wr_rdn, addr, data} (MSB first) and returns the read byte.
//   clk, rstb            : system clock, synchronous active-low reset
//   ena                  : block enable (sampled only while idle)
//   mode                 : [1] CPOL, [0] CPHA (sampled at accept)
//   req_valid/req_ready  : request handshake
//   req_wr_rdn           : 1 = write, 0 = read
//   req_addr, req_wdata  : register address and write data
//   rsp_valid            : one-cycle completion pulse
//   rsp_rdata            : read byte (0 after a write), held until next rsp
//   busy                 : high from accept until back in IDLE
//   spi_cs_n, spi_clk, spi_mosi, spi_miso : SPI pins
// ---------------------------------------------------------------------------
module spi_controller
    import spi_ctrl_pkg::*;
#(
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr_rdn,
    input  logic [REG_W-2:0] req_addr,
    input  logic [REG_W-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [REG_W-1:0] rsp_rdata,
    output logic             busy,
    output logic             spi_cs_n,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    state_t             state_reg;
    logic               cpol_reg;
    logic               cpha_reg;
    logic               wr_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic [4:0]         edge_cnt_reg;
    logic [REG_W-1:0]   rx_reg;
    logic               req_ready_reg;
    logic               rsp_valid_reg;
    logic [REG_W-1:0]   rsp_rdata_reg;
    logic               busy_reg;
    logic               cs_n_reg;
    logic               mosi_reg;

    logic               tick;
    logic               sclk_cpol;
    logic [FRAME_W-1:0] frame_in;
    logic               sample_now;
    logic [3:0]         shift_idx;

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign busy      = busy_reg;
    assign spi_cs_n  = cs_n_reg;
    assign spi_mosi  = mosi_reg;

    // Reads carry zeros in the data field.
    assign frame_in  = pack_frame(req_wr_rdn, req_addr, req_wr_rdn ? req_wdata : '0);

    // SCLK follows the live mode only while idle; a frame uses the latched CPOL.
    assign sclk_cpol = (state_reg == IDLE) ? mode[CPOL_BIT] : cpol_reg;

    // Edge k (0-based) within SHIFT: samples fall on k[0]==CPHA, launches on
    // the other parity. The bit launched at edge k is 15-((k+1)>>1); for
    // CPHA=1 the first launch re-presents bit 15.
    assign sample_now = (edge_cnt_reg[0] == cpha_reg);
    assign shift_idx  = 4'd15 - 4'((edge_cnt_reg + 5'd1) >> 1);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rstb   (rstb),
        .hold   (state_reg == IDLE),
        .toggle (state_reg == SHIFT),
        .cpol   (sclk_cpol),
        .tick   (tick),
        .sclk   (spi_clk)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_reg     <= IDLE;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            wr_reg        <= 1'b0;
            frame_reg     <= '0;
            edge_cnt_reg  <= '0;
            rx_reg        <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            busy_reg      <= 1'b0;
            cs_n_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= ena;
                    if (req_valid && req_ready_reg) begin
                        frame_reg     <= frame_in;
                        wr_reg        <= req_wr_rdn;
                        cpol_reg      <= mode[CPOL_BIT];
                        cpha_reg      <= mode[CPHA_BIT];
                        busy_reg      <= 1'b1;
                        cs_n_reg      <= 1'b0;
                        mosi_reg      <= frame_in[FRAME_W-1];
                        req_ready_reg <= 1'b0;
                        edge_cnt_reg  <= '0;
                        state_reg     <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        edge_cnt_reg <= '0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        edge_cnt_reg <= edge_cnt_reg + 5'd1;
                        if (sample_now) begin
                            // Only the second half of the frame carries read data.
                            if (edge_cnt_reg[4]) begin
                                rx_reg <= {rx_reg[REG_W-2:0], spi_miso};
                            end
                        end else if (edge_cnt_reg != 5'd31) begin
                            mosi_reg <= frame_reg[shift_idx];
                        end
                        if (edge_cnt_reg == 5'd31) begin
                            state_reg <= LAG;
                        end
                    end
                end
                LAG: begin
                    if (tick) begin
                        cs_n_reg      <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= wr_reg ? '0 : rx_reg;
                        edge_cnt_reg  <= '0;
                        state_reg     <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (edge_cnt_reg == 5'(CS_GAP - 1)) begin
                            busy_reg      <= 1'b0;
                            req_ready_reg <= ena;
                            state_reg     <= IDLE;
                        end else begin
                            edge_cnt_reg <= edge_cnt_reg + 5'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_controller
// Directed bench for spi_controller with CLK_DIV=2, CS_GAP=2. A behavioural
// SPI register peripheral answers frames; expected responses are queued at
// request time and checked when rsp_valid pulses.
// ---------------------------------------------------------------------------
module tb_spi_controller;

    localparam int REG_W   = 8;
    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;
    localparam int LAT     = 34 * CLK_DIV + 1;
    localparam int CS_LOW  = 34 * CLK_DIV;
    localparam int GAP_CYC = CS_GAP * CLK_DIV;

    logic             clk;
    logic             rstb;
    logic             ena;
    logic [1:0]       mode;
    logic             req_valid;
    logic             req_ready;
    logic             req_wr_rdn;
    logic [REG_W-2:0] req_addr;
    logic [REG_W-1:0] req_wdata;
    logic             rsp_valid;
    logic [REG_W-1:0] rsp_rdata;
    logic             busy;
    logic             spi_cs_n;
    logic             spi_clk;
    logic             spi_mosi;
    logic             spi_miso;

    spi_controller #(
        .REG_W   (REG_W),
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .ena        (ena),
        .mode       (mode),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr_rdn (req_wr_rdn),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .spi_cs_n   (spi_cs_n),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  rdata;
        logic [15:0] frame;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    // ---------------- behavioural SPI register peripheral ----------------
    logic [1:0]  slave_mode;
    logic [7:0]  s_mem [128];
    logic [15:0] s_rx;
    logic [15:0] s_last_frame;
    logic [7:0]  s_data;
    int          s_cnt;
    int          s_j;
    logic        s_cs_prev;
    logic        s_clk_prev;
    logic        s_lead;

    task automatic s_present();
        if (s_j >= 8 && s_j < 16) spi_miso = s_data[3'(15 - s_j)];
        else                      spi_miso = 1'b0;
    endtask

    always @(spi_clk or spi_cs_n) begin
        if (spi_cs_n !== s_cs_prev) begin
            if (spi_cs_n === 1'b0) begin
                s_cnt = 0; s_j = 0; s_rx = '0; s_data = '0;
                s_present();
            end else begin
                s_last_frame = s_rx;
                if (s_cnt == 16 && s_rx[15]) s_mem[s_rx[14:8]] = s_rx[7:0];
            end
            s_cs_prev = spi_cs_n;
        end
        if (spi_clk !== s_clk_prev) begin
            if (spi_cs_n === 1'b0) begin
                s_lead = (spi_clk != slave_mode[1]);
                if (s_lead == !slave_mode[0]) begin
                    s_rx = {s_rx[14:0], spi_mosi};
                    s_cnt++;
                    if (s_cnt == 8) s_data = s_rx[7] ? 8'h00 : s_mem[s_rx[6:0]];
                end else if (slave_mode[0] == 1'b0) begin
                    s_j++;
                    s_present();
                end else begin
                    s_present();
                    s_j++;
                end
            end
            s_clk_prev = spi_clk;
        end
    end

    // ---------------- monitor / scoreboard (samples on negedge) ----------
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   rise_cyc = 0;
    int   rsp_cnt  = 0;
    int   acc_cnt  = 0;
    int   acc_cyc  = 0;
    logic mon_cs_prev = 1'b1;
    exp_t mon_e;
    int   mon_a;

    always @(negedge clk) begin
        cyc++;
        if (mon_cs_prev === 1'b1 && spi_cs_n === 1'b0) fall_cyc = cyc;
        if (mon_cs_prev === 1'b0 && spi_cs_n === 1'b1) rise_cyc = cyc;
        mon_cs_prev = spi_cs_n;
        if (req_valid && req_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
            acc_q.push_back(cyc);
        end
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                chk("latency", 32'(cyc - mon_a), 32'(LAT));
                chk("cs_low_cycles", 32'(rise_cyc - fall_cyc), 32'(CS_LOW));
                chk("mosi_frame", 32'(s_last_frame), 32'(mon_e.frame));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_accept(input int a0);
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            step(1);
            if (acc_cnt != a0) done = 1;
        end
        chk("accept", 32'(acc_cnt), 32'(a0 + 1));
    endtask

    task automatic wait_rsp(input int target);
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            step(1);
            if (rsp_cnt >= target) done = 1;
        end
        chk("rsp_seen", 32'(rsp_cnt), 32'(target));
    endtask

    task automatic do_xfer(input logic [1:0] m, input logic wr, input logic [6:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_rd, input bit drop_ena);
        exp_t e;
        int   a0;
        int   r0;
        mode = m; slave_mode = m;
        step(2);
        e.rdata = exp_rd;
        e.frame = {wr, addr, wr ? wd : 8'h00};
        exp_q.push_back(e);
        a0 = acc_cnt; r0 = rsp_cnt;
        req_valid = 1'b1; req_wr_rdn = wr; req_addr = addr; req_wdata = wd;
        wait_accept(a0);
        req_valid = 1'b0;
        if (drop_ena) begin
            step(5);
            ena = 1'b0;
        end
        wait_rsp(r0 + 1);
        step(3);
        chk("rdata_hold", 32'(rsp_rdata), 32'(exp_rd));
        chk("sclk_park", 32'(spi_clk), 32'(m[1]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int r0;
        int hi;
        int low;
        int edges;
        logic prev;
        bit done;

        for (int i = 0; i < 128; i++) s_mem[i] = 8'h00;
        s_mem[7'h7F] = 8'h96;
        s_cs_prev = 1'b1; s_clk_prev = 1'b0; spi_miso = 1'b0;
        s_rx = '0; s_last_frame = '0; s_data = '0; s_cnt = 0; s_j = 0; s_lead = 1'b0;
        slave_mode = 2'b11;

        // Reset with CPOL=1 requested: SCLK must still reset to 0.
        rstb = 1'b0; ena = 1'b1; mode = 2'b11; req_valid = 1'b0;
        req_wr_rdn = 1'b0; req_addr = '0; req_wdata = '0;
        step(3);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_clk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstb = 1'b1;
        step(2);
        chk("idle_sclk_cpol1", 32'(spi_clk), 32'd1);
        chk("idle_ready", 32'(req_ready), 32'd1);

        // Mode 0 write: frame 0x85A5, rdata 0.
        do_xfer(2'd0, 1'b1, 7'h05, 8'hA5, 8'h00, 0);

        // Mode 3 write then read back through the peripheral.
        do_xfer(2'd3, 1'b1, 7'h02, 8'h3C, 8'h00, 0);
        do_xfer(2'd3, 1'b0, 7'h02, 8'hFF, 8'h3C, 0);

        // Modes 1 and 2 read of 0x7F (frame 0x7F00), plus a cross-mode write/read.
        do_xfer(2'd1, 1'b0, 7'h7F, 8'hFF, 8'h96, 0);
        do_xfer(2'd2, 1'b0, 7'h7F, 8'h00, 8'h96, 0);
        do_xfer(2'd1, 1'b1, 7'h11, 8'h5A, 8'h00, 0);
        do_xfer(2'd2, 1'b0, 7'h11, 8'h00, 8'h5A, 0);

        // Back-to-back with req_valid held high.
        mode = 2'd0; slave_mode = 2'd0;
        step(2);
        exp_q.push_back('{rdata: 8'h00, frame: 16'h9033});
        exp_q.push_back('{rdata: 8'h33, frame: 16'h1000});
        a0 = acc_cnt; r0 = rsp_cnt;
        req_valid = 1'b1; req_wr_rdn = 1'b1; req_addr = 7'h10; req_wdata = 8'h33;
        wait_accept(a0);
        req_wr_rdn = 1'b0; req_wdata = 8'h00;
        hi = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            step(1);
            if (req_ready) hi++;
            if (acc_cnt == a0 + 2) done = 1;
        end
        req_valid = 1'b0;
        chk("b2b_second_accept", 32'(acc_cnt), 32'(a0 + 2));
        chk("b2b_ready_samples", 32'(hi), 32'd1);
        chk("b2b_gap", 32'(acc_cyc - rise_cyc), 32'(GAP_CYC));
        wait_rsp(r0 + 2);

        // Abort with rstb during SHIFT (CPOL=1 so SCLK=0 is a real reset effect).
        mode = 2'd2; slave_mode = 2'd2;
        step(2);
        a0 = acc_cnt; r0 = rsp_cnt;
        req_valid = 1'b1; req_wr_rdn = 1'b1; req_addr = 7'h20; req_wdata = 8'hC3;
        wait_accept(a0);
        req_valid = 1'b0;
        edges = 0; prev = spi_clk;
        for (int i = 0; i < 200 && edges < 10; i++) begin
            step(1);
            if (spi_clk !== prev) begin
                edges++;
                prev = spi_clk;
            end
        end
        chk("abort_edges", 32'(edges), 32'd10);
        rstb = 1'b0;
        step(1);
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_sclk", 32'(spi_clk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        rstb = 1'b1;
        step(100);
        chk("abort_no_rsp", 32'(rsp_cnt), 32'(r0));
        acc_q.delete();
        do_xfer(2'd2, 1'b0, 7'h20, 8'h00, 8'h00, 0);
        do_xfer(2'd0, 1'b0, 7'h7F, 8'h00, 8'h96, 0);

        // ena low blocks requests.
        ena = 1'b0;
        step(2);
        a0 = acc_cnt;
        req_valid = 1'b1; req_wr_rdn = 1'b0; req_addr = 7'h7F;
        hi = 0; low = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (req_ready) hi++;
            if (!spi_cs_n) low++;
        end
        req_valid = 1'b0;
        chk("ena0_ready", 32'(hi), 32'd0);
        chk("ena0_cs_low", 32'(low), 32'd0);
        chk("ena0_accepts", 32'(acc_cnt), 32'(a0));
        ena = 1'b1;
        step(2);

        // ena dropped mid-frame: frame completes, exactly one rsp_valid.
        do_xfer(2'd2, 1'b0, 7'h11, 8'h00, 8'h5A, 1);
        r0 = rsp_cnt;
        step(80);
        chk("ena_drop_single_rsp", 32'(rsp_cnt), 32'(r0));
        chk("ena_drop_ready", 32'(req_ready), 32'd0);
        ena = 1'b1;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI initiator that drives the register-access frame consumed by the team's SPI register peripheral.
- Converts a parallel request (wr_rdn, 7-bit address, 8-bit write data) into one 16-bit frame and returns the 8-bit read data.
- Used by on-chip test logic and by the FPGA bench to reach the register bank through the real SPI pins.
- Frame, MSB first: bit15 = wr_rdn (1 = write), bits14:8 = addr[6:0], bits7:0 = data (wdata on MOSI for writes; rdata sampled from MISO for reads).

Parameters:
- REG_W, 8, data width in bits; the frame is 1+(REG_W-1)+REG_W = 16 bits.
- CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 2.
- CS_GAP, 2, minimum number of SCLK half-periods with spi_cs_n high between frames.

Ports:
- clk  in  1  system clock.
- rstb  in  1  reset: one clock; synchronous, active-low.
- ena  in  1  block enable.
- mode  in  2  SPI mode: [1] = CPOL, [0] = CPHA.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid and ready are both high.
- req_wr_rdn  in  1  1 = write, 0 = read.
- req_addr  in  REG_W-1  register address.
- req_wdata  in  REG_W  write data.
- rsp_valid  out  1  one-cycle pulse at transaction completion.
- rsp_rdata  out  REG_W  read data; 0 after a write.
- busy  out  1  high from accept until return to IDLE.
- spi_cs_n  out  1  chip select, active low.
- spi_clk  out  1  SCLK.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.

Behaviour:
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, state=IDLE.
- A half-period tick pulses every CLK_DIV clk cycles.
  - The divider counter clears on every state entry.
  - The counter is held at 0 while in IDLE.
- IDLE
  - req_ready = ena.
  - spi_clk = mode[1], registered.
  - On accept: latch mode, the 16-bit frame, and the operation type; set busy=1; drive spi_cs_n=0 and spi_mosi=frame[15] in the next cycle; go to LEAD.
- LEAD: one half-period of setup; go to SHIFT on the tick.
- SHIFT: 32 ticks, and spi_clk toggles on each tick.
  - CPHA=0: sample MISO on odd ticks (leading edge); shift MOSI to the next bit on even ticks (trailing edge). The last trailing edge does not shift.
  - CPHA=1: shift MOSI on odd ticks (the first leading edge presents bit15, which is already valid); sample on even ticks.
  - A 5-bit edge counter selects the bit. Only the samples of bits 7:0 are kept, into an 8-bit shift register, MSB first.
- LAG: one half-period with spi_cs_n=0 and spi_clk at the latched CPOL.
  - On the tick: spi_cs_n=1, rsp_valid=1 for one cycle, rsp_rdata = sampled byte for a read or 0 for a write; go to GAP.
- GAP: CS_GAP half-periods with spi_cs_n high, then IDLE with busy=0.
  - A request can be accepted no earlier than the first IDLE cycle.
- Latency: accept to rsp_valid = (34*CLK_DIV)+1 cycles. spi_cs_n stays low for exactly 34*CLK_DIV cycles.
- Inputs are ignored while busy: mode, req_* and ena. A frame in progress always completes even if ena falls. rsp_rdata holds its value until the next rsp_valid.
- rstb low in any state: synchronous return to the reset values on the next clk edge. The frame is abandoned, no rsp_valid is produced, and spi_cs_n rises immediately.
- spi_miso is treated as synchronous to the SCLK edges generated here; no synchronizer is needed because the sample point lags the launch by CLK_DIV >= 2 clk cycles.

Decomposition:
- spi_ctrl_pkg holds:
  - state enum (IDLE, LEAD, SHIFT, LAG, GAP);
  - FRAME_W = 16;
  - CPOL_BIT = 1 and CPHA_BIT = 0;
  - a frame-pack function {wr_rdn, addr, data}.
- One sub-module, spi_sclk_gen: divider counter, tick pulse, and SCLK toggle/park, with a CPOL input and a tick output.
- Both the FSM and the shifters stay in spi_controller.

Test Plan:
- CLK_DIV=2, mode 0, write addr 0x05 data 0xA5:
  - MOSI sampled on rising SCLK = 0x85A5;
  - spi_cs_n low for 68 cycles;
  - rsp_valid at accept+69 with rsp_rdata=0x00.
- Mode 3 loopback against the SPI register peripheral + reg_bank:
  - write 0x3C to addr 0x02, then read addr 0x02 → rsp_rdata=0x3C;
  - SCLK parks high between frames.
- Modes 1 and 2, a MISO model returning 0x96 on a read of addr 0x7F → rsp_rdata=0x96; MOSI carries 0x7F00.
- Back-to-back with req_valid held high:
  - the second accept occurs exactly CS_GAP*CLK_DIV cycles after spi_cs_n rises;
  - req_ready=0 throughout the first frame.
- rstb low at SHIFT edge 10:
  - next cycle spi_cs_n=1, spi_clk=0, busy=0, and no rsp_valid;
  - a following request completes normally.
- ena=0 with req_valid=1 → req_ready=0 and spi_cs_n stays high; ena dropped mid-frame → the frame completes and rsp_valid pulses once.
